mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_mc_control.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle control unit for a small RISC-V style datapath.
//
// Sequences fetch, decode, execute, memory access and write-back. It drives
// the datapath register loads, the operand/memory muxes and the ALU operation,
// and it flags illegal opcodes and memory timeouts.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   opcode, funct3,    instruction fields taken from the IR (valid from DECODE)
//   funct7_5
//   alu_zero           ALU zero flag, used to resolve branches
//   mem_ready          completion strobe for instruction and data memory
//   inst_read, data_read, data_write   memory requests
//   ir_write, pc_write, pc_source      IR/PC load control
//   reg_write, load_a, load_b, load_aluout, load_mdr   datapath loads
//   sel_mux_a, sel_mux_b, sel_mux_mem, alu_op          datapath steering
//   state              current state code
//   exc_cause          00 none, 01 illegal, 10 fetch timeout, 11 data timeout
//   instret            retired-instruction counter (wraps)
module mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             inst_read,
  output logic             data_read,
  output logic             data_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_source,
  output logic             reg_write,
  output logic             load_a,
  output logic             load_b,
  output logic             load_aluout,
  output logic             load_mdr,
  output logic             sel_mux_a,
  output logic [1:0]       sel_mux_b,
  output logic             sel_mux_mem,
  output logic [2:0]       alu_op,
  output logic [3:0]       state,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_EXEC_I = 4'd4,
    ST_ADDR   = 4'd5,
    ST_MEM_LD = 4'd6,
    ST_MEM_ST = 4'd7,
    ST_WB_ALU = 4'd8,
    ST_WB_MEM = 4'd9,
    ST_BRANCH = 4'd10,
    ST_EXCEPT = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_FETCH   = 2'b10;
  localparam logic [1:0] EXC_DATA    = 2'b11;

  // Last wait-count value before a stalled memory access is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [7:0]       wait_cnt_r;
  logic [1:0]       exc_cause_r;
  logic [1:0]       exc_next_s;
  logic [CNT_W-1:0] instret_r;
  logic             retire_s;
  logic             wait_state_s;
  logic             timeout_s;

  assign state     = state_r;
  assign exc_cause = exc_cause_r;
  assign instret   = instret_r;

  assign wait_state_s = (state_r == ST_FETCH) || (state_r == ST_MEM_LD) ||
                        (state_r == ST_MEM_ST);
  // A ready strobe in the final wait cycle still completes the access.
  assign timeout_s = wait_state_s && !mem_ready && (wait_cnt_r == WAIT_LAST);

  // Next-state, exception cause, retire and datapath control decode.
  always_comb begin
    state_next_s = state_r;
    exc_next_s   = exc_cause_r;
    retire_s     = 1'b0;
    inst_read    = 1'b0;
    data_read    = 1'b0;
    data_write   = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_source    = 1'b0;
    reg_write    = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_aluout  = 1'b0;
    load_mdr     = 1'b0;
    sel_mux_a    = 1'b0;
    sel_mux_b    = 2'b00;
    sel_mux_mem  = 1'b0;
    alu_op       = ALU_NONE;

    case (state_r)
      ST_RESET: begin
        state_next_s = ST_FETCH;
      end

      ST_FETCH: begin
        // PC + 4 is computed while the instruction is being read.
        inst_read = 1'b1;
        sel_mux_b = 2'b01;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          state_next_s = ST_DECODE;
        end else if (timeout_s) begin
          state_next_s = ST_EXCEPT;
          exc_next_s   = EXC_FETCH;
        end else begin
          state_next_s = ST_FETCH;
        end
      end

      ST_DECODE: begin
        // Branch target (PC + imm<<1) is precomputed into AluOut here.
        load_a      = 1'b1;
        load_b      = 1'b1;
        sel_mux_b   = 2'b11;
        alu_op      = ALU_ADD;
        load_aluout = 1'b1;
        case (opcode)
          OP_R: begin
            state_next_s = ST_EXEC_R;
          end
          OP_IMM: begin
            if (funct3 == 3'b000) begin
              state_next_s = ST_EXEC_I;
            end else begin
              state_next_s = ST_EXCEPT;
              exc_next_s   = EXC_ILLEGAL;
            end
          end
          OP_LOAD, OP_STORE: begin
            if (funct3 == 3'b011) begin
              state_next_s = ST_ADDR;
            end else begin
              state_next_s = ST_EXCEPT;
              exc_next_s   = EXC_ILLEGAL;
            end
          end
          OP_BRANCH: begin
            if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
              state_next_s = ST_BRANCH;
            end else begin
              state_next_s = ST_EXCEPT;
              exc_next_s   = EXC_ILLEGAL;
            end
          end
          default: begin
            state_next_s = ST_EXCEPT;
            exc_next_s   = EXC_ILLEGAL;
          end
        endcase
      end

      ST_EXEC_R: begin
        sel_mux_a = 1'b1;
        sel_mux_b = 2'b00;
        case ({funct7_5, funct3})
          4'b0000: begin
            alu_op       = ALU_ADD;
            load_aluout  = 1'b1;
            state_next_s = ST_WB_ALU;
          end
          4'b1000: begin
            alu_op       = ALU_SUB;
            load_aluout  = 1'b1;
            state_next_s = ST_WB_ALU;
          end
          4'b0111: begin
            alu_op       = ALU_AND;
            load_aluout  = 1'b1;
            state_next_s = ST_WB_ALU;
          end
          4'b0110: begin
            alu_op       = ALU_OR;
            load_aluout  = 1'b1;
            state_next_s = ST_WB_ALU;
          end
          default: begin
            state_next_s = ST_EXCEPT;
            exc_next_s   = EXC_ILLEGAL;
          end
        endcase
      end

      ST_EXEC_I, ST_ADDR: begin
        sel_mux_a   = 1'b1;
        sel_mux_b   = 2'b10;
        alu_op      = ALU_ADD;
        load_aluout = 1'b1;
        if (state_r == ST_EXEC_I) begin
          state_next_s = ST_WB_ALU;
        end else if (opcode == OP_STORE) begin
          state_next_s = ST_MEM_ST;
        end else begin
          state_next_s = ST_MEM_LD;
        end
      end

      ST_MEM_LD: begin
        data_read = 1'b1;
        if (mem_ready) begin
          load_mdr     = 1'b1;
          state_next_s = ST_WB_MEM;
        end else if (timeout_s) begin
          state_next_s = ST_EXCEPT;
          exc_next_s   = EXC_DATA;
        end else begin
          state_next_s = ST_MEM_LD;
        end
      end

      ST_MEM_ST: begin
        data_write = 1'b1;
        if (mem_ready) begin
          retire_s     = 1'b1;
          state_next_s = ST_FETCH;
        end else if (timeout_s) begin
          state_next_s = ST_EXCEPT;
          exc_next_s   = EXC_DATA;
        end else begin
          state_next_s = ST_MEM_ST;
        end
      end

      ST_WB_ALU, ST_WB_MEM: begin
        reg_write    = 1'b1;
        sel_mux_mem  = (state_r == ST_WB_MEM);
        retire_s     = 1'b1;
        state_next_s = ST_FETCH;
      end

      ST_BRANCH: begin
        sel_mux_a = 1'b1;
        sel_mux_b = 2'b00;
        alu_op    = ALU_SUB;
        pc_source = 1'b1;
        if (funct3 == 3'b000) begin
          pc_write = alu_zero;
        end else begin
          pc_write = ~alu_zero;
        end
        retire_s     = 1'b1;
        state_next_s = ST_FETCH;
      end

      ST_EXCEPT: begin
        state_next_s = ST_EXCEPT;
      end

      default: begin
        // Unused encodings recover through RESET.
        state_next_s = ST_RESET;
        exc_next_s   = EXC_NONE;
      end
    endcase
  end

  // State and exception-cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RESET;
      exc_cause_r <= EXC_NONE;
    end else begin
      state_r     <= state_next_s;
      exc_cause_r <= exc_next_s;
    end
  end

  // Memory wait counter: restarts whenever a state is entered, counts stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
    end else if (state_next_s != state_r) begin
      wait_cnt_r <= 8'd0;
    end else if (wait_state_s && !mem_ready) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_r <= '0;
    end else if (retire_s) begin
      instret_r <= instret_r + CNT_W'(1);
    end else begin
      instret_r <= instret_r;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;
  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          funct7_5 = 1'b0;
  logic          alu_zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          inst_read, data_read, data_write, ir_write, pc_write, pc_source;
  logic          reg_write, load_a, load_b, load_aluout, load_mdr, sel_mux_a;
  logic [1:0]    sel_mux_b;
  logic          sel_mux_mem;
  logic [2:0]    alu_op;
  logic [3:0]    state;
  logic [1:0]    exc_cause;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  mc_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .inst_read(inst_read),
    .data_read(data_read), .data_write(data_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .reg_write(reg_write),
    .load_a(load_a), .load_b(load_b), .load_aluout(load_aluout), .load_mdr(load_mdr),
    .sel_mux_a(sel_mux_a), .sel_mux_b(sel_mux_b), .sel_mux_mem(sel_mux_mem),
    .alu_op(alu_op), .state(state), .exc_cause(exc_cause), .instret(instret)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] cause;
    logic       inst_read, data_read, data_write, ir_write, pc_write, pc_source;
    logic       reg_write, load_a, load_b, load_aluout, load_mdr, sel_mux_a;
    logic [1:0] sel_mux_b;
    logic       sel_mux_mem;
    logic [2:0] alu_op;
  } outs_t;

  typedef struct packed {
    logic [6:0]    op;
    logic [2:0]    f3;
    logic          f7;
    logic          mr;
    logic          az;
    logic          rs;
    outs_t         o;
    logic [CW-1:0] ir;
  } entry_t;

  outs_t dut_o;
  assign dut_o = {state, exc_cause, inst_read, data_read, data_write, ir_write,
                  pc_write, pc_source, reg_write, load_a, load_b, load_aluout,
                  load_mdr, sel_mux_a, sel_mux_b, sel_mux_mem, alu_op};

  // Expected-cycle table built from instruction-level descriptions.
  entry_t        tab [0:511];
  outs_t         seen_o [0:511];
  logic [CW-1:0] seen_ir [0:511];
  int            n = 0;
  logic [CW-1:0] m_ir = '0;
  logic [1:0]    m_cause = 2'b00;
  int            tot_ret = 0;
  int            wrap_idx = -1;
  logic [6:0]    cur_op = 7'd0;
  logic [2:0]    cur_f3 = 3'd0;
  logic          cur_f7 = 1'b0;
  logic          cur_az = 1'b0;
  logic          cur_rs = 1'b0;
  int            checks = 0;
  int            errors = 0;

  function automatic outs_t base(input logic [3:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    o.cause = m_cause;
    return o;
  endfunction

  task automatic push(input logic mr, input outs_t o);
    tab[n].op = cur_op;
    tab[n].f3 = cur_f3;
    tab[n].f7 = cur_f7;
    tab[n].az = cur_az;
    tab[n].rs = cur_rs;
    tab[n].mr = mr;
    tab[n].o  = o;
    tab[n].ir = m_ir;
    n++;
  endtask

  task automatic retire();
    m_ir = m_ir + 4'd1;
    tot_ret++;
    if (tot_ret == 16) wrap_idx = n;
  endtask

  task automatic except_cycles(input int k);
    repeat (k) push(1'b1, base(4'd15));
  endtask

  // Request/ready handshake in FETCH(1), MEM_LD(6) or MEM_ST(7); ready after w stalls.
  task automatic wait_phase(input logic [3:0] st, input int w, input logic [1:0] tcause,
                            output bit ok);
    outs_t o;
    bit    done;
    ok = 1'b0;
    done = 1'b0;
    for (int i = 0; i <= w && !done; i++) begin
      o = base(st);
      if (st == 4'd1) begin
        o.inst_read = 1'b1;
        o.sel_mux_b = 2'b01;
        o.alu_op = 3'b001;
      end
      if (st == 4'd6) o.data_read = 1'b1;
      if (st == 4'd7) o.data_write = 1'b1;
      if (i == w) begin
        if (st == 4'd1) begin
          o.ir_write = 1'b1;
          o.pc_write = 1'b1;
        end
        if (st == 4'd6) o.load_mdr = 1'b1;
        push(1'b1, o);
        ok = 1'b1;
        done = 1'b1;
      end else begin
        push(1'b0, o);
        if (i == TO - 1) begin
          m_cause = tcause;
          done = 1'b1;
        end
      end
    end
  endtask

  // One instruction: fw fetch stalls, mw data stalls, branch flag az.
  task automatic exec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic az, input int fw, input int mw);
    outs_t      o;
    bit         ok;
    int         kind;
    logic [2:0] alu;
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_az = az;
    wait_phase(4'd1, fw, 2'b10, ok);
    if (!ok) begin
      except_cycles(2);
    end else begin
      o = base(4'd2);
      o.load_a = 1'b1; o.load_b = 1'b1; o.sel_mux_b = 2'b11;
      o.alu_op = 3'b001; o.load_aluout = 1'b1;
      push(1'b1, o);
      if (op == 7'b0110011) kind = 1;
      else if (op == 7'b0010011 && f3 == 3'd0) kind = 2;
      else if (op == 7'b0000011 && f3 == 3'd3) kind = 3;
      else if (op == 7'b0100011 && f3 == 3'd3) kind = 4;
      else if (op == 7'b1100011 && f3 <= 3'd1) kind = 5;
      else kind = 0;
      case (kind)
        1: begin
          case ({f7, f3})
            4'b0000: alu = 3'b001;
            4'b1000: alu = 3'b010;
            4'b0111: alu = 3'b011;
            4'b0110: alu = 3'b100;
            default: alu = 3'b000;
          endcase
          o = base(4'd3);
          o.sel_mux_a = 1'b1;
          o.alu_op = alu;
          o.load_aluout = (alu != 3'b000);
          push(1'b1, o);
          if (alu == 3'b000) begin
            m_cause = 2'b01;
            except_cycles(2);
          end else begin
            o = base(4'd8); o.reg_write = 1'b1; push(1'b1, o); retire();
          end
        end
        2, 3, 4: begin
          o = base(kind == 2 ? 4'd4 : 4'd5);
          o.sel_mux_a = 1'b1; o.sel_mux_b = 2'b10; o.alu_op = 3'b001; o.load_aluout = 1'b1;
          push(1'b1, o);
          if (kind == 2) begin
            o = base(4'd8); o.reg_write = 1'b1; push(1'b1, o); retire();
          end else if (kind == 3) begin
            wait_phase(4'd6, mw, 2'b11, ok);
            if (ok) begin
              o = base(4'd9); o.reg_write = 1'b1; o.sel_mux_mem = 1'b1;
              push(1'b1, o); retire();
            end else begin
              except_cycles(2);
            end
          end else begin
            wait_phase(4'd7, mw, 2'b11, ok);
            if (ok) retire();
            else except_cycles(2);
          end
        end
        5: begin
          o = base(4'd10);
          o.sel_mux_a = 1'b1; o.alu_op = 3'b010; o.pc_source = 1'b1;
          o.pc_write = (f3 == 3'd0) ? az : ~az;
          push(1'b1, o); retire();
        end
        default: begin
          m_cause = 2'b01;
          except_cycles(2);
        end
      endcase
    end
  endtask

  // Assert rst during the last tabled cycle, hold extra cycles, then release.
  task automatic rst_after_last(input int extra);
    tab[n-1].rs = 1'b1;
    m_ir = '0;
    m_cause = 2'b00;
    cur_rs = 1'b1;
    repeat (extra) push(1'b0, base(4'd0));
    cur_rs = 1'b0;
    push(1'b0, base(4'd0));
  endtask

  task automatic pin(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  int a_add, a_ld, a_br, a_to, a_il, a_mid;
  int dr_cnt, mdr_cnt;

  initial begin
    outs_t o;
    // Build the expected trace.
    push(1'b0, base(4'd0));
    a_add = n;
    exec(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);   // add
    exec(7'b0110011, 3'd0, 1'b1, 1'b0, 1, 0);   // sub, 1 fetch stall
    exec(7'b0110011, 3'd6, 1'b0, 1'b0, 0, 0);   // or
    exec(7'b0110011, 3'd7, 1'b0, 1'b0, 0, 0);   // and
    exec(7'b0010011, 3'd0, 1'b0, 1'b0, 2, 0);   // addi
    a_ld = n;
    exec(7'b0000011, 3'd3, 1'b0, 1'b0, 0, 3);   // ld, 3 data stalls
    exec(7'b0100011, 3'd3, 1'b0, 1'b0, 0, 1);   // sd
    a_br = n;
    exec(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);   // beq taken
    exec(7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);   // bne not taken
    exec(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);   // bne taken
    exec(7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0);   // beq not taken
    exec(7'b0110011, 3'd0, 1'b0, 1'b0, 3, 0);   // ready on last allowed cycle
    for (int i = 0; i < 6; i++) exec(7'b0010011, 3'd0, 1'b0, 1'b0, 0, 0);
    exec(7'b0010011, 3'd0, 1'b0, 1'b0, 0, 0);
    rst_after_last(0);                          // reset wins over retire
    exec(7'b0110011, 3'd7, 1'b1, 1'b0, 0, 0);   // bad R funct
    rst_after_last(1);
    a_il = n;
    exec(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);   // illegal opcode
    rst_after_last(0);
    a_to = n;
    exec(7'b0110011, 3'd0, 1'b0, 1'b0, 20, 0);  // fetch timeout
    rst_after_last(0);
    exec(7'b0000011, 3'd3, 1'b0, 1'b0, 0, 20);  // load timeout
    rst_after_last(0);
    exec(7'b0100011, 3'd3, 1'b0, 1'b0, 0, 20);  // store timeout
    rst_after_last(0);
    o = base(4'd1); o.inst_read = 1'b1; o.sel_mux_b = 2'b01; o.alu_op = 3'b001;
    push(1'b0, o); push(1'b0, o);
    rst_after_last(0);                          // reset mid fetch wait
    a_mid = n;
    exec(7'b0110011, 3'd0, 1'b0, 1'b0, 3, 0);
    exec(7'b0100011, 3'd3, 1'b0, 1'b0, 0, 0);

    // Replay the trace and compare every cycle.
    repeat (2) @(posedge clk);
    for (int i = 0; i < n; i++) begin
      #1;
      rst = tab[i].rs; opcode = tab[i].op; funct3 = tab[i].f3; funct7_5 = tab[i].f7;
      alu_zero = tab[i].az; mem_ready = tab[i].mr;
      @(negedge clk);
      seen_o[i] = dut_o;
      seen_ir[i] = instret;
      checks++;
      if (dut_o !== tab[i].o) begin
        errors++;
        $display("FAIL outs cyc=%0d got=%h expected=%h", i, dut_o, tab[i].o);
      end
      checks++;
      if (instret !== tab[i].ir) begin
        errors++;
        $display("FAIL instret cyc=%0d got=%0d expected=%0d", i, instret, tab[i].ir);
      end
      @(posedge clk);
    end

    // Hand-computed expectations on the recorded DUT behaviour.
    pin("reset_state", seen_o[0].st, 0);
    pin("add_s0", seen_o[a_add].st, 1);
    pin("add_s1", seen_o[a_add+1].st, 2);
    pin("add_s2", seen_o[a_add+2].st, 3);
    pin("add_s3", seen_o[a_add+3].st, 8);
    pin("add_s4", seen_o[a_add+4].st, 1);
    pin("add_regwr", seen_o[a_add+3].reg_write, 1);
    pin("add_instret0", seen_ir[a_add+3], 0);
    pin("add_instret1", seen_ir[a_add+4], 1);
    dr_cnt = 0; mdr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      dr_cnt += seen_o[a_ld+i].data_read;
      mdr_cnt += seen_o[a_ld+i].load_mdr;
    end
    pin("ld_data_read", dr_cnt, 4);
    pin("ld_load_mdr", mdr_cnt, 1);
    pin("ld_wb_mem", seen_o[a_ld+7].st, 9);
    pin("ld_latency", seen_o[a_ld+8].st, 1);
    pin("beq_pcwr", seen_o[a_br+2].pc_write, 1);
    pin("beq_pcsrc", seen_o[a_br+2].pc_source, 1);
    pin("bne_pcwr", seen_o[a_br+5].pc_write, 0);
    pin("br_instret", seen_ir[a_br+6] - seen_ir[a_br], 2);
    pin("wrap_pre", seen_ir[wrap_idx-1], 15);
    pin("wrap_post", seen_ir[wrap_idx], 0);
    pin("illegal_state", seen_o[a_il+2].st, 15);
    pin("illegal_cause", seen_o[a_il+2].cause, 1);
    pin("to_fetch4", seen_o[a_to+3].st, 1);
    pin("to_except", seen_o[a_to+4].st, 15);
    pin("to_cause", seen_o[a_to+4].cause, 2);
    pin("mid_ready4", seen_o[a_mid+4].st, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
